tile_dispatcher: RTL and testbench

//  Accepts one triangle (3 fixed-point vertices + color) per handshake and computes its screen-clamped tile bounding box.

---
 rtl/tile_dispatcher_pkg.sv | 55 +++++
 rtl/tile_dispatcher_rr_arbiter.sv | 39 +++
 rtl/tile_dispatcher.sv | 269 ++++++++++++++++++++++++++
 tb/tb_tile_dispatcher.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// tile_dispatcher_pkg
// Shared raster types and defaults for the tile dispatcher slice.
//   coord_3d_t        signed fixed-point vertex (x, y, z)
//   metadata_t        per-tile descriptor handed to a tile_processor
//   dispatch_state_t  dispatcher FSM encoding
//   fx_min3/fx_max3   three-way signed min/max used by the bbox setup
// -----------------------------------------------------------------------------
package tile_dispatcher_pkg;

  localparam int FX_FRAC_BITS   = 4;
  localparam int FX_TOTAL_BITS  = 16;
  localparam int DEF_TILE_SHIFT = 5;
  localparam int DEF_TILES_X    = 20;
  localparam int DEF_TILES_Y    = 15;
  localparam int DEF_TILE_IDX_W = 8;
  localparam int DEF_NUM_UNITS  = 4;
  localparam int COLOR_W        = 4;

  typedef logic signed [FX_TOTAL_BITS-1:0] fx_t;

  typedef struct packed {
    fx_t x;
    fx_t y;
    fx_t z;
  } coord_3d_t;

  typedef struct packed {
    logic [DEF_TILE_IDX_W-1:0] tile_x;
    logic [DEF_TILE_IDX_W-1:0] tile_y;
    logic [COLOR_W-1:0]        color;
  } metadata_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    SELECT = 2'd2,
    HOLD   = 2'd3
  } dispatch_state_t;

  function automatic fx_t fx_min3(input fx_t a, input fx_t b, input fx_t c);
    fx_t m;
    m = (a < b) ? a : b;
    m = (c < m) ? c : m;
    return m;
  endfunction

  function automatic fx_t fx_max3(input fx_t a, input fx_t b, input fx_t c);
    fx_t m;
    m = (a > b) ? a : b;
    m = (c > m) ? c : m;
    return m;
  endfunction

endpackage

// File: rtl/tile_dispatcher_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tile_dispatcher_rr_arbiter
// Combinational round-robin pick: first requester at or above ptr_i, wrapping.
//   req_i        per-unit request (unit ready)
//   ptr_i        index the scan starts from
//   grant_oh_o   one-hot grant (zero when nothing requests)
//   grant_idx_o  binary index of the grant
//   found_o      at least one request was present
// -----------------------------------------------------------------------------
module tile_dispatcher_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     grant_oh_o,
  output logic [PTR_W-1:0] grant_idx_o,
  output logic             found_o
);

  // Scan from ptr_i upward; only the first hit is kept.
  always_comb begin
    int   idx;
    logic hit;
    grant_oh_o  = '0;
    grant_idx_o = '0;
    found_o     = 1'b0;
    idx         = 0;
    hit         = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx             = (int'(ptr_i) + k) % N;
      hit             = req_i[idx] & ~found_o;
      grant_oh_o[idx] = grant_oh_o[idx] | hit;
      grant_idx_o     = hit ? PTR_W'(idx) : grant_idx_o;
      found_o         = found_o | hit;
    end
  end

endmodule

// File: rtl/tile_dispatcher.sv
// -----------------------------------------------------------------------------
// tile_dispatcher
// Accepts one triangle per handshake, computes its screen-clamped tile bounding
// box, walks it row-major and issues one metadata_t per tile to a round-robin
// selected tile_processor. Vertices are broadcast to all units.
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   tri_vld / tri_rdy      triangle handshake (tri_rdy registered)
//   tri_v0/1/2, tri_color  triangle vertices (signed FX) and color
//   unit_rdy / unit_vld    per-unit handshake, unit_vld at most one-hot
//   out_v0/1/2, out_meta   latched vertices and current tile descriptor
//   busy                   FSM not in IDLE
// Optional build macro TILE_DISPATCH_STATS_EN adds saturating 32-bit counters
// stat_tiles (fires), stat_culled (culled triangles), stat_stall (SELECT stalls).
// -----------------------------------------------------------------------------
module tile_dispatcher
  import tile_dispatcher_pkg::*;
#(
  parameter int NUM_UNITS  = DEF_NUM_UNITS,
  parameter int TILES_X    = DEF_TILES_X,
  parameter int TILES_Y    = DEF_TILES_Y,
  parameter int TILE_SHIFT = DEF_TILE_SHIFT,
  parameter int TILE_IDX_W = DEF_TILE_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tri_vld,
  output logic                 tri_rdy,
  input  coord_3d_t            tri_v0,
  input  coord_3d_t            tri_v1,
  input  coord_3d_t            tri_v2,
  input  logic [COLOR_W-1:0]   tri_color,
  input  logic [NUM_UNITS-1:0] unit_rdy,
  output logic [NUM_UNITS-1:0] unit_vld,
  output coord_3d_t            out_v0,
  output coord_3d_t            out_v1,
  output coord_3d_t            out_v2,
  output metadata_t            out_meta,
  output logic                 busy
`ifdef TILE_DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_tiles,
  output logic [31:0]          stat_culled,
  output logic [31:0]          stat_stall
`endif
);

  localparam int  PTR_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int  SHAMT  = FX_FRAC_BITS + TILE_SHIFT;
  localparam fx_t X_LAST = fx_t'(TILES_X - 1);
  localparam fx_t Y_LAST = fx_t'(TILES_Y - 1);

  dispatch_state_t        state_q, state_d;
  logic                   tri_rdy_q, tri_rdy_d;
  logic [NUM_UNITS-1:0]   unit_vld_q, unit_vld_d;
  coord_3d_t              v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [COLOR_W-1:0]     color_q, color_d;
  metadata_t              meta_q, meta_d;
  logic [PTR_W-1:0]       grant_q, grant_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [TILE_IDX_W-1:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [TILE_IDX_W-1:0]  min_x_q, min_x_d, max_x_q, max_x_d;
  logic [TILE_IDX_W-1:0]  min_y_q, min_y_d, max_y_q, max_y_d;

  // Bounding box in tile units; arithmetic shift keeps negative coordinates negative.
  fx_t                    bx_min_s, bx_max_s, by_min_s, by_max_s;
  logic                   cull_s;
  logic [TILE_IDX_W-1:0]  lo_x_s, hi_x_s, lo_y_s, hi_y_s;

  assign bx_min_s = fx_min3(v0_q.x, v1_q.x, v2_q.x) >>> SHAMT;
  assign bx_max_s = fx_max3(v0_q.x, v1_q.x, v2_q.x) >>> SHAMT;
  assign by_min_s = fx_min3(v0_q.y, v1_q.y, v2_q.y) >>> SHAMT;
  assign by_max_s = fx_max3(v0_q.y, v1_q.y, v2_q.y) >>> SHAMT;

  assign cull_s = (bx_max_s < fx_t'(0)) | (bx_min_s > X_LAST) |
                  (by_max_s < fx_t'(0)) | (by_min_s > Y_LAST);

  // Clamp to the screen; only meaningful when the triangle is not culled.
  assign lo_x_s = (bx_min_s < fx_t'(0)) ? '0 : bx_min_s[TILE_IDX_W-1:0];
  assign hi_x_s = (bx_max_s > X_LAST) ? X_LAST[TILE_IDX_W-1:0] : bx_max_s[TILE_IDX_W-1:0];
  assign lo_y_s = (by_min_s < fx_t'(0)) ? '0 : by_min_s[TILE_IDX_W-1:0];
  assign hi_y_s = (by_max_s > Y_LAST) ? Y_LAST[TILE_IDX_W-1:0] : by_max_s[TILE_IDX_W-1:0];

  logic [NUM_UNITS-1:0] arb_oh_s;
  logic [PTR_W-1:0]     arb_idx_s;
  logic                 arb_found_s;

  tile_dispatcher_rr_arbiter #(
    .N     (NUM_UNITS),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i       (unit_rdy),
    .ptr_i       (rr_ptr_q),
    .grant_oh_o  (arb_oh_s),
    .grant_idx_o (arb_idx_s),
    .found_o     (arb_found_s)
  );

  logic fire_s, last_x_s, last_tile_s;
  assign fire_s      = (state_q == HOLD) & unit_vld_q[grant_q] & unit_rdy[grant_q];
  assign last_x_s    = (cur_x_q == max_x_q);
  assign last_tile_s = last_x_s & (cur_y_q == max_y_q);

  // Next-state and output-register logic of the dispatch FSM.
  always_comb begin
    state_d    = state_q;
    tri_rdy_d  = tri_rdy_q;
    unit_vld_d = unit_vld_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    color_d    = color_q;
    meta_d     = meta_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    min_x_d    = min_x_q;
    max_x_d    = max_x_q;
    min_y_d    = min_y_q;
    max_y_d    = max_y_q;
    case (state_q)
      IDLE: begin
        if (tri_vld && tri_rdy_q) begin
          v0_d      = tri_v0;
          v1_d      = tri_v1;
          v2_d      = tri_v2;
          color_d   = tri_color;
          tri_rdy_d = 1'b0;
          state_d   = SETUP;
        end else begin
          tri_rdy_d = 1'b1;
        end
      end
      SETUP: begin
        if (cull_s) begin
          tri_rdy_d = 1'b1;
          state_d   = IDLE;
        end else begin
          min_x_d = lo_x_s;
          max_x_d = hi_x_s;
          min_y_d = lo_y_s;
          max_y_d = hi_y_s;
          cur_x_d = lo_x_s;
          cur_y_d = lo_y_s;
          state_d = SELECT;
        end
      end
      SELECT: begin
        if (arb_found_s) begin
          grant_d       = arb_idx_s;
          unit_vld_d    = arb_oh_s;
          meta_d.tile_x = DEF_TILE_IDX_W'(cur_x_q);
          meta_d.tile_y = DEF_TILE_IDX_W'(cur_y_q);
          meta_d.color  = color_q;
          state_d       = HOLD;
        end else begin
          unit_vld_d = '0;
        end
      end
      HOLD: begin
        if (fire_s) begin
          unit_vld_d = '0;
          rr_ptr_d   = (grant_q == PTR_W'(NUM_UNITS - 1)) ? '0 : grant_q + PTR_W'(1);
          if (last_tile_s) begin
            tri_rdy_d = 1'b1;
            state_d   = IDLE;
          end else begin
            if (last_x_s) begin
              cur_x_d = min_x_q;
              cur_y_d = cur_y_q + TILE_IDX_W'(1);
            end else begin
              cur_x_d = cur_x_q + TILE_IDX_W'(1);
            end
            state_d = SELECT;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d    = IDLE;
        tri_rdy_d  = 1'b1;
        unit_vld_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tri_rdy_q  <= 1'b1;
      unit_vld_q <= '0;
      v0_q       <= '0;
      v1_q       <= '0;
      v2_q       <= '0;
      color_q    <= '0;
      meta_q     <= '0;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      min_x_q    <= '0;
      max_x_q    <= '0;
      min_y_q    <= '0;
      max_y_q    <= '0;
    end else begin
      state_q    <= state_d;
      tri_rdy_q  <= tri_rdy_d;
      unit_vld_q <= unit_vld_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      color_q    <= color_d;
      meta_q     <= meta_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      min_x_q    <= min_x_d;
      max_x_q    <= max_x_d;
      min_y_q    <= min_y_d;
      max_y_q    <= max_y_d;
    end
  end

  assign tri_rdy  = tri_rdy_q;
  assign unit_vld = unit_vld_q;
  assign out_v0   = v0_q;
  assign out_v1   = v1_q;
  assign out_v2   = v2_q;
  assign out_meta = meta_q;
  assign busy     = (state_q != IDLE);

`ifdef TILE_DISPATCH_STATS_EN
  logic [31:0] stat_tiles_q, stat_culled_q, stat_stall_q;

  // Saturating event counters; observe only, never feed back into dispatch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_tiles_q  <= 32'd0;
      stat_culled_q <= 32'd0;
      stat_stall_q  <= 32'd0;
    end else begin
      if (fire_s && (stat_tiles_q != 32'hFFFF_FFFF)) begin
        stat_tiles_q <= stat_tiles_q + 32'd1;
      end else begin
        stat_tiles_q <= stat_tiles_q;
      end
      if ((state_q == SETUP) && cull_s && (stat_culled_q != 32'hFFFF_FFFF)) begin
        stat_culled_q <= stat_culled_q + 32'd1;
      end else begin
        stat_culled_q <= stat_culled_q;
      end
      if ((state_q == SELECT) && !arb_found_s && (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end else begin
        stat_stall_q <= stat_stall_q;
      end
    end
  end

  assign stat_tiles  = stat_tiles_q;
  assign stat_culled = stat_culled_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_tile_dispatcher.sv
// -----------------------------------------------------------------------------
// tb_tile_dispatcher
// Directed scoreboard bench: each issued triangle pushes its hand-computed
// tiles (unit, tile_x, tile_y, color, v0.x) into a queue; a monitor pops and
// compares on every unit_vld/unit_rdy fire.
// -----------------------------------------------------------------------------
module tb_tile_dispatcher;
  import tile_dispatcher_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tri_vld;
  logic       tri_rdy;
  coord_3d_t  tri_v0, tri_v1, tri_v2;
  logic [3:0] tri_color;
  logic [3:0] unit_rdy;
  logic [3:0] unit_vld;
  coord_3d_t  out_v0, out_v1, out_v2;
  metadata_t  out_meta;
  logic       busy;
`ifdef TILE_DISPATCH_STATS_EN
  logic [31:0] stat_tiles, stat_culled, stat_stall;
`endif

  tile_dispatcher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tri_vld   (tri_vld),
    .tri_rdy   (tri_rdy),
    .tri_v0    (tri_v0),
    .tri_v1    (tri_v1),
    .tri_v2    (tri_v2),
    .tri_color (tri_color),
    .unit_rdy  (unit_rdy),
    .unit_vld  (unit_vld),
    .out_v0    (out_v0),
    .out_v1    (out_v1),
    .out_v2    (out_v2),
    .out_meta  (out_meta),
    .busy      (busy)
`ifdef TILE_DISPATCH_STATS_EN
    ,
    .stat_tiles  (stat_tiles),
    .stat_culled (stat_culled),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  unit;
    logic [7:0]  tx;
    logic [7:0]  ty;
    logic [3:0]  col;
    logic [15:0] v0x;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic coord_3d_t pt(input int px, input int py);
    coord_3d_t c;
    c.x = fx_t'(px * 16);
    c.y = fx_t'(py * 16);
    c.z = fx_t'(0);
    return c;
  endfunction

  task automatic push(input int u, input int tx, input int ty, input int col, input int px0);
    exp_t e;
    e.unit = 8'(u);
    e.tx   = 8'(tx);
    e.ty   = 8'(ty);
    e.col  = 4'(col);
    e.v0x  = 16'(px0 * 16);
    sb.push_back(e);
  endtask

  // Called at #1 after a posedge with tri_rdy high; returns #1 after the accept edge.
  task automatic send(input coord_3d_t a, input coord_3d_t b, input coord_3d_t c, input int col);
    tri_v0    = a;
    tri_v1    = b;
    tri_v2    = c;
    tri_color = 4'(col);
    tri_vld   = 1'b1;
    @(posedge clk);
    #1;
    tri_vld = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(tri_rdy === 1'b1 && busy === 1'b0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_idle"}, 64'(tri_rdy === 1'b1 && busy === 1'b0), 64'd1);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    tri_vld   = 1'b0;
    tri_v0    = '0;
    tri_v1    = '0;
    tri_v2    = '0;
    tri_color = 4'd0;
    unit_rdy  = 4'hF;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst_n === 1'b1 && unit_vld !== 4'b0000) begin
            int   u;
            exp_t e;
            u = 0;
            check("vld_onehot", 64'($countones(unit_vld)), 64'd1);
            for (int i = 0; i < 4; i++) begin
              if (unit_vld[i]) u = i;
            end
            if (unit_rdy[u]) begin
              if (sb.size() == 0) begin
                check("fire_unexpected", 64'(u), 64'hFF);
              end else begin
                e = sb.pop_front();
                check("fire_tile",
                      64'({8'(u), out_meta.tile_x, out_meta.tile_y, out_meta.color, out_v0.x}),
                      64'(e));
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_tri_rdy", 64'(tri_rdy), 64'd1);
    check("rst_unit_vld", 64'(unit_vld), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_meta", 64'(out_meta), 64'd0);
    check("rst_v0", 64'(out_v0), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single tile, latency T+3
    push(0, 0, 0, 5, 0);
    send(pt(0, 0), pt(31, 0), pt(0, 31), 5);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_rdy_drop", 64'(tri_rdy), 64'd0);
    check("t1_vld_T1", 64'(unit_vld), 64'd0);
    @(posedge clk); #1;
    check("t1_vld_T2", 64'(unit_vld), 64'd0);
    @(posedge clk); #1;
    check("t1_vld_T3", 64'(unit_vld), 64'b0001);
    @(posedge clk); #1;
    check("t1_vld_after_fire", 64'(unit_vld), 64'd0);
    check("t1_rdy_after_fire", 64'(tri_rdy), 64'd1);
    wait_idle("t1");

    // 2: 3x2 tiles from fresh rr pointer
    do_reset();
    push(0, 0, 0, 9, 10); push(1, 1, 0, 9, 10); push(2, 2, 0, 9, 10);
    push(3, 0, 1, 9, 10); push(0, 1, 1, 9, 10); push(1, 2, 1, 9, 10);
    send(pt(10, 10), pt(70, 10), pt(10, 40), 9);
    wait_idle("t2");

    // 3: culled off the left edge
    send(pt(-100, 50), pt(-100, 60), pt(-100, 70), 4);
    check("t3_rdy_T1", 64'(tri_rdy), 64'd0);
    @(posedge clk); #1;
    check("t3_rdy_T2", 64'(tri_rdy), 64'd1);
    check("t3_busy_T2", 64'(busy), 64'd0);
    check("t3_vld", 64'(unit_vld), 64'd0);
`ifdef TILE_DISPATCH_STATS_EN
    check("t3_stat_culled", 64'(stat_culled), 64'd1);
`endif

    // 4: clamped bottom-right corner, rr continues from unit 2
    push(2, 18, 12, 3, 600); push(3, 19, 12, 3, 600);
    push(0, 18, 13, 3, 600); push(1, 19, 13, 3, 600);
    push(2, 18, 14, 3, 600); push(3, 19, 14, 3, 600);
    send(pt(600, 400), pt(700, 500), pt(650, 450), 3);
    wait_idle("t4");

    // 5: degenerate triangle, skip of a non-ready unit, then stalls
    push(0, 3, 3, 6, 100);
    send(pt(100, 100), pt(100, 100), pt(100, 100), 6);
    wait_idle("t5a");
    unit_rdy = 4'b1101;
    push(2, 1, 2, 8, 40);
    send(pt(40, 70), pt(40, 70), pt(40, 70), 8);
    wait_idle("t5b");
    unit_rdy = 4'b0000;
    push(3, 0, 0, 7, 0);
    send(pt(0, 0), pt(0, 0), pt(0, 0), 7);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t5_stall_vld", 64'(unit_vld), 64'd0);
    end
    unit_rdy = 4'hF;
    wait_idle("t5c");
`ifdef TILE_DISPATCH_STATS_EN
    check("t5_stat_stall", 64'(stat_stall), 64'd5);
    check("t5_stat_tiles", 64'(stat_tiles), 64'd15);
`endif

    // 6: reset while holding a tile
    send(pt(10, 10), pt(70, 10), pt(10, 40), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    unit_rdy = 4'b0000;
    check("t6_hold_vld", 64'(unit_vld), 64'b0001);
    @(posedge clk); #1;
    check("t6_still_hold", 64'(unit_vld), 64'b0001);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_vld", 64'(unit_vld), 64'd0);
    check("t6_rst_rdy", 64'(tri_rdy), 64'd1);
    check("t6_rst_busy", 64'(busy), 64'd0);
    rst_n    = 1'b1;
    unit_rdy = 4'hF;
    @(posedge clk); #1;
    push(0, 0, 0, 2, 0);
    send(pt(0, 0), pt(31, 0), pt(0, 31), 2);
    wait_idle("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
